// File: rtl/multi_master_bus_pkg.sv
// Shared types for the multi-master bus: FSM state encoding and its width.
package multi_master_bus_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last owner.
module rr_arbiter #(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0]         req_i,
    input  logic [$clog2(M)-1:0] last_owner_i,
    output logic [M-1:0]         win_o,
    output logic                 any_o
);

    localparam int unsigned LW = $clog2(M);

    logic [LW-1:0] idx;
    logic          found;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= M; i++) begin
            idx = LW'((int'(last_owner_i) + i) % M);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/multi_master_bus.sv
// Registered multiplexed bus for M masters with round-robin ownership, bounded hold and turnaround gap.
// Optional even-parity output enabled by MULTI_MASTER_BUS_PARITY_EN.
module multi_master_bus
    import multi_master_bus_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req,
    input  logic [M*N-1:0] data_in,
    output logic [M-1:0]   grant,
    output logic [N-1:0]   bus_data,
    output logic           bus_valid,
`ifdef MULTI_MASTER_BUS_PARITY_EN
    output logic           bus_parity,
`endif
    output logic [M-1:0]   rx_valid
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned TURN_W = $clog2(TURN_CYC + 1);
    localparam int unsigned OWN_W  = $clog2(M);

    state_e            state_q, state_d;
    logic [M-1:0]      grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [TURN_W-1:0] turn_q, turn_d, turn_inc;
    logic [OWN_W-1:0]  last_q, last_d, owner_idx;
    logic [N-1:0]      bus_data_q, bus_data_d, owner_data;
    logic              bus_valid_q, bus_valid_d;
    logic [M-1:0]      rx_valid_q, rx_valid_d;
    logic              owner_req;
    logic [M-1:0]      arb_win;
    logic              arb_any;

    rr_arbiter #(.M(M)) u_arb (
        .req_i        (req),
        .last_owner_i (last_q),
        .win_o        (arb_win),
        .any_o        (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            last_q      <= OWN_W'(M - 1);
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            rx_valid_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            turn_q      <= turn_d;
            last_q      <= last_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    // Owner's request/data/index selected by the one-hot grant.
    always_comb begin
        owner_data = '0;
        owner_idx  = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (grant_q[k]) begin
                owner_data = data_in[k*N +: N];
                owner_idx  = OWN_W'(k);
            end
        end
        owner_req = |(req & grant_q);
        hold_inc  = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
        turn_inc  = (turn_q == TURN_W'(TURN_CYC)) ? turn_q : turn_q + TURN_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        last_d      = last_q;
        bus_data_d  = bus_data_q;
        bus_valid_d = 1'b0;
        rx_valid_d  = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = GRANT;
                    grant_d = arb_win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                hold_d = hold_inc;
                if (owner_req) begin
                    bus_valid_d = 1'b1;
                    bus_data_d  = owner_data;
                    rx_valid_d  = ~grant_q;
                end
                if (!owner_req || hold_inc >= HOLD_W'(MAX_HOLD)) begin
                    state_d = TURN;
                    grant_d = '0;
                    last_d  = owner_idx;
                    hold_d  = '0;
                    turn_d  = '0;
                end
            end
            TURN: begin
                turn_d = turn_inc;
                // Last gap cycle re-arbitrates with the updated pointer.
                if (turn_inc >= TURN_W'(TURN_CYC)) begin
                    turn_d = '0;
                    if (arb_any) begin
                        state_d = GRANT;
                        grant_d = arb_win;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef MULTI_MASTER_BUS_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^bus_data_d;
        end
    end

    assign bus_parity = parity_q;
`endif

    assign grant     = grant_q;
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_multi_master_bus.sv
// Self-checking bench for multi_master_bus: directed scenarios plus randomized traffic vs a behavioural model.
module tb_multi_master_bus;

    localparam int N        = 8;
    localparam int M        = 4;
    localparam int MAX_HOLD = 4;
    localparam int TURN_CYC = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   req;
    logic [M*N-1:0] data_in;
    logic [M-1:0]   grant;
    logic [N-1:0]   bus_data;
    logic           bus_valid;
    logic [M-1:0]   rx_valid;
`ifdef MULTI_MASTER_BUS_PARITY_EN
    logic           bus_parity;
`endif

    always #5 clk = ~clk;

    multi_master_bus #(
        .N(N), .M(M), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .bus_data   (bus_data),
        .bus_valid  (bus_valid),
`ifdef MULTI_MASTER_BUS_PARITY_EN
        .bus_parity (bus_parity),
`endif
        .rx_valid   (rx_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 = none), granted cycles used, gap cycles left.
    int m_owner = -1;
    int m_used  = 0;
    int m_gap   = 0;
    int m_last  = M - 1;
    logic [M-1:0] e_grant = '0;
    logic [M-1:0] e_rx    = '0;
    logic [N-1:0] e_data  = '0;
    logic         e_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [M-1:0] r, input int last);
        int k;
        for (int i = 1; i <= M; i++) begin
            k = (last + i) % M;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        e_valid = 1'b0;
        e_rx    = '0;
        if (rst) begin
            m_owner = -1; m_used = 0; m_gap = 0; m_last = M - 1; e_data = '0;
        end else if (m_owner >= 0) begin
            m_used++;
            if (req[m_owner]) begin
                e_valid = 1'b1;
                e_data  = data_in[m_owner*N +: N];
                e_rx    = ~(M'(1) << m_owner);
            end
            if (!req[m_owner] || m_used == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = TURN_CYC;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
                w = pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_used  = 0;
                end
            end
        end
        e_grant = (m_owner >= 0) ? (M'(1) << m_owner) : '0;
    endtask

    // Drive one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic cycle(input logic r, input logic [M-1:0] rq, input logic [M*N-1:0] d);
        rst = r; req = rq; data_in = d;
        model_step();
        @(negedge clk);
        check("grant", grant, e_grant);
        check("bus_valid", bus_valid, e_valid);
        check("rx_valid", rx_valid, e_rx);
        check("bus_data", bus_data, e_data);
`ifdef MULTI_MASTER_BUS_PARITY_EN
        check("bus_parity", bus_parity, ^e_data);
`endif
    endtask

    function automatic logic [M*N-1:0] rnd_data();
        logic [M*N-1:0] v;
        for (int k = 0; k < M; k++) v[k*N +: N] = N'($urandom);
        return v;
    endfunction

    task automatic do_reset();
        repeat (2) cycle(1'b1, M'($urandom), rnd_data());
        check("reset_grant", grant, 0);
        check("reset_valid", bus_valid, 0);
    endtask

    initial begin
        logic [M*N-1:0] d;
        logic [M-1:0]   rq;
        int t;

        // Reset, then first grant goes to master 0.
        do_reset();
        cycle(1'b0, 4'b1001, rnd_data());
        check("first_grant", grant, 4'b0001);

        // Hold limit with a sole requester.
        do_reset();
        d = rnd_data();
        d[2*N +: N] = 8'hA5;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 4'b0100, d);
            t = c + 1;
            if (t >= 1 && t <= 4) check("hold_grant", grant, 4'b0100);
            if (t == 5) check("hold_gap", grant, 0);
            if (t == 6) check("hold_regrant", grant, 4'b0100);
            if (t >= 2 && t <= 5) begin
                check("hold_data", bus_data, 8'hA5);
                check("hold_rx", rx_valid, 4'b1011);
            end
        end

        // Round-robin with all masters requesting.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            cycle(1'b0, 4'hF, rnd_data());
            t = c + 1;
            if (t % 5 == 1) check("rr_owner", grant, M'(1) << ((t / 5) % M));
        end

        // Early release.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            rq = (c < 2) ? 4'b0010 : 4'b0000;
            cycle(1'b0, rq, rnd_data());
            t = c + 1;
            if (t <= 2) check("early_grant", grant, 4'b0010);
            else check("early_grant", grant, 0);
            check("early_valid", bus_valid, (t == 2) ? 1 : 0);
        end

        // Reset in the middle of master 3's burst.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b1000, rnd_data());
        cycle(1'b1, 4'b1000, rnd_data());
        check("midrst_grant", grant, 0);
        check("midrst_valid", bus_valid, 0);
        cycle(1'b0, 4'b1001, rnd_data());
        check("midrst_winner", grant, 4'b0001);

`ifdef MULTI_MASTER_BUS_PARITY_EN
        do_reset();
        d = '0;
        d[0 +: N] = 8'h07;
        cycle(1'b0, 4'b0001, d);
        cycle(1'b0, 4'b0001, d);
        check("par_data7", bus_data, 8'h07);
        check("par_odd", bus_parity, 1);
        d[0 +: N] = 8'h03;
        cycle(1'b0, 4'b0001, d);
        check("par_data3", bus_data, 8'h03);
        check("par_even", bus_parity, 0);
`endif

        // Randomized traffic with sparse request toggling and occasional reset.
        do_reset();
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < M; k++)
                if ($urandom_range(3, 0) == 0) rq[k] = ~rq[k];
            cycle(($urandom_range(199, 0) == 0), rq, rnd_data());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
